board_gpio_ctrl: RTL and testbench
==================================

BOARD_GPIO_CTRL -- requirements
Module: board_gpio_ctrl

Interface
REQ-001 SHALL have parameter SW_WIDTH, default 16: number of switch input channels.
REQ-002 SHALL have parameter LED_WIDTH, default 16: number of LED output channels.
REQ-003 SHALL have parameter GPIO_WIDTH, default 32: width of the CPU-facing input bus.
REQ-004 SHALL have parameter SW_OFFSET, default 8: LSB position of the switch field in gpio_bi_o. SW_OFFSET+SW_WIDTH <= GPIO_WIDTH is required, and an elaboration error SHALL fire otherwise.
REQ-005 SHALL have parameter DEB_CYCLES, default 100000: debounce qualification length in clocks (1 ms at 100 MHz). Minimum value is 2.
REQ-006 SHALL have parameter PWM_BITS, default 4: width of the LED brightness control.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock. All logic is rising-edge.
REQ-008 SHALL have port srst_i, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port sw_i, input, SW_WIDTH bits: raw asynchronous switch pads.
REQ-010 SHALL have port gpio_bi_o, output, GPIO_WIDTH bits: debounced switches placed at [SW_OFFSET +: SW_WIDTH], all other bits 0.
REQ-011 SHALL have port led_bo_i, input, LED_WIDTH bits: LED pattern from the CPU GPIO output.
REQ-012 SHALL have port bright_i, input, PWM_BITS bits: global LED brightness.
REQ-013 SHALL have port led_o, output, LED_WIDTH bits: PWM-gated LED pads.
REQ-014 SHALL have port sw_chg_o, output, SW_WIDTH bits: sticky per-channel change flags.
REQ-015 SHALL have port irq_o, output, 1 bit: change interrupt, level.
REQ-016 SHALL have port irq_ack_i, input, 1 bit: single-cycle pulse that clears all change flags.

Function
REQ-017 Each sw_i bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-018 Debounce counter, per channel:
- SHALL increment each cycle the synchronized bit differs from the stable bit.
- SHALL clear on any cycle the two are equal.
REQ-019 When the counter equals DEB_CYCLES-1 and the bits still differ, the stable bit SHALL take the synchronized value on that edge and the counter SHALL clear.
- Result: pad-to-gpio_bi_o latency = DEB_CYCLES+2 clocks.
- A glitch shorter than DEB_CYCLES synchronized cycles SHALL produce no change.
REQ-020 gpio_bi_o SHALL be driven directly from the stable registers (no extra stage).
REQ-021 On any stable-bit transition (either direction), the corresponding sw_chg_o bit SHALL set on the same edge.
REQ-022 irq_o SHALL equal the registered OR-reduction of sw_chg_o (one clock after the flag sets).
REQ-023 irq_ack_i=1 SHALL clear all sw_chg_o bits. If a new transition occurs in the same cycle, that channel's bit SHALL remain set (set wins over clear).
REQ-024 PWM counter SHALL be PWM_BITS wide, free-running, and wrap from all-ones to 0.
REQ-025 bright_i SHALL be sampled into a brightness register only on the cycle the PWM counter is all-ones, so that it takes effect from the next period.
REQ-026 led_bo_i SHALL be registered every cycle.
REQ-027 led_o[i] SHALL be registered and equal led_reg[i] AND duty_on, where:
- duty_on = 1 if bright_reg is all-ones;
- otherwise duty_on = (pwm_cnt < bright_reg).
REQ-028 Resulting duty cycle: bright=0 gives off; bright=k gives k/2^PWM_BITS; all-ones gives 100%.
REQ-029 led_o latency from led_bo_i SHALL be 2 clocks at 100% brightness.

Reset
REQ-030 While srst_i=1, the following SHALL be 0 at the next edge: synchronizers, debounce counters, stable bits, sw_chg_o, irq_o, PWM counter, bright_reg, led_reg, led_o, gpio_bi_o.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count. After release, a held pad SHALL requalify with the full DEB_CYCLES+2 latency.
REQ-032 A switch held high through reset release SHALL generate a change flag when it qualifies.

Structure
REQ-033 Package board_gpio_pkg SHALL hold:
- default parameter values;
- a function returning the debounce counter width, $clog2(DEB_CYCLES).
REQ-034 Sub-module gpio_debounce SHALL implement one channel (synchronizer, counter, stable bit, transition pulse). It SHALL be instantiated SW_WIDTH times via generate.
REQ-035 PWM logic and the change/irq logic SHALL reside in board_gpio_ctrl.

Verification (DEB_CYCLES=4, PWM_BITS=4, SW_WIDTH=16, SW_OFFSET=8)
REQ-036 sw_i=16'h0001 held → gpio_bi_o=32'h00000100 exactly 6 clocks later; sw_chg_o=16'h0001 on that edge; irq_o=1 one clock later.
REQ-037 sw_i[3] pulsed high for 3 clocks → gpio_bi_o and sw_chg_o unchanged for 20 clocks.
REQ-038 With sw_chg_o=16'h0001, irq_ack_i pulsed in the same cycle sw_i[5] qualifies → sw_chg_o=16'h0020; irq_o remains 1.
REQ-039 led_bo_i=16'hFFFF, bright_i=4'h4 → each LED high exactly 4 of every 16 clocks; bright_i changed mid-period takes effect only after the counter wraps.
REQ-040 srst_i asserted after 2 qualifying clocks on sw_i[0], then released → no flag before 6 clocks post-release; flag at 6.

Source files
------------

// File: rtl/board_gpio_pkg.sv
// ----------------------------------------------------------------------------
// board_gpio_pkg
//   Shared defaults for the board GPIO controller and a helper that sizes the
//   per-channel debounce counter.
//   No ports; imported by gpio_debounce and board_gpio_ctrl.
// ----------------------------------------------------------------------------
package board_gpio_pkg;

    localparam int unsigned DEF_SW_WIDTH   = 16;
    localparam int unsigned DEF_LED_WIDTH  = 16;
    localparam int unsigned DEF_GPIO_WIDTH = 32;
    localparam int unsigned DEF_SW_OFFSET  = 8;
    localparam int unsigned DEF_DEB_CYCLES = 100000;   // 1 ms at 100 MHz
    localparam int unsigned DEF_PWM_BITS   = 4;

    // Counter only has to reach DEB_CYCLES-1, so clog2 of the cycle count
    // is exactly enough bits.
    function automatic int unsigned deb_cnt_width(input int unsigned deb_cycles);
        return $clog2(deb_cycles);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// ----------------------------------------------------------------------------
// gpio_debounce
//   One switch channel: 2-flop synchronizer, qualification counter and the
//   debounced (stable) bit.
//   Ports:
//     clk_i    - clock, rising edge
//     srst_i   - synchronous active-high reset
//     pad_i    - raw asynchronous switch pad
//     stable_o - debounced level (registered)
//     toggle_o - combinational pulse, high in the cycle whose closing edge
//                flips stable_o
// ----------------------------------------------------------------------------
module gpio_debounce
    import board_gpio_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic pad_i,
    output logic stable_o,
    output logic toggle_o
);

    localparam int unsigned       CNT_W    = deb_cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q,   sync_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             stable_q, stable_d;
    logic             differ;

    // Counter runs only while the synchronized level disagrees with the
    // stable level; any agreement restarts qualification from zero.
    always_comb begin
        sync_d   = {sync_q[0], pad_i};
        differ   = sync_q[1] ^ stable_q;
        cnt_d    = '0;
        stable_d = stable_q;
        toggle_o = 1'b0;
        if (differ) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                toggle_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/board_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// board_gpio_ctrl
//   Board-level GPIO glue: debounced switches onto the CPU input bus with
//   sticky change flags and a level interrupt, plus PWM-dimmed LED outputs.
//   Ports:
//     clk_i      - clock, rising edge
//     srst_i     - synchronous active-high reset
//     sw_i       - raw switch pads [SW_WIDTH]
//     gpio_bi_o  - CPU input bus, debounced switches at [SW_OFFSET +: SW_WIDTH]
//     led_bo_i   - LED pattern from CPU [LED_WIDTH]
//     bright_i   - global LED brightness [PWM_BITS]
//     led_o      - PWM-gated LED pads [LED_WIDTH]
//     sw_chg_o   - sticky per-switch change flags [SW_WIDTH]
//     irq_o      - level interrupt, registered OR of sw_chg_o
//     irq_ack_i  - pulse clearing all change flags (new changes win)
// ----------------------------------------------------------------------------
module board_gpio_ctrl
    import board_gpio_pkg::*;
#(
    parameter int unsigned SW_WIDTH   = DEF_SW_WIDTH,
    parameter int unsigned LED_WIDTH  = DEF_LED_WIDTH,
    parameter int unsigned GPIO_WIDTH = DEF_GPIO_WIDTH,
    parameter int unsigned SW_OFFSET  = DEF_SW_OFFSET,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic [SW_WIDTH-1:0]   sw_i,
    output logic [GPIO_WIDTH-1:0] gpio_bi_o,
    input  logic [LED_WIDTH-1:0]  led_bo_i,
    input  logic [PWM_BITS-1:0]   bright_i,
    output logic [LED_WIDTH-1:0]  led_o,
    output logic [SW_WIDTH-1:0]   sw_chg_o,
    output logic                  irq_o,
    input  logic                  irq_ack_i
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (SW_OFFSET + SW_WIDTH > GPIO_WIDTH) begin : g_bad_sw_field
        $error("board_gpio_ctrl: SW_OFFSET+SW_WIDTH exceeds GPIO_WIDTH");
    end

    if (DEB_CYCLES < 2) begin : g_bad_deb_cycles
        $error("board_gpio_ctrl: DEB_CYCLES must be at least 2");
    end

    // ------------------------------------------------------------------
    // Switch debounce channels
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] sw_stable;
    logic [SW_WIDTH-1:0] sw_toggle;

    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_deb
        gpio_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk_i    (clk_i),
            .srst_i   (srst_i),
            .pad_i    (sw_i[g]),
            .stable_o (sw_stable[g]),
            .toggle_o (sw_toggle[g])
        );
    end

    // Stable registers feed the bus directly; unused bits tie low.
    always_comb begin
        gpio_bi_o = '0;
        gpio_bi_o[SW_OFFSET +: SW_WIDTH] = sw_stable;
    end

    // ------------------------------------------------------------------
    // Change flags and interrupt
    // ------------------------------------------------------------------
    logic [SW_WIDTH-1:0] chg_q, chg_d;
    logic                irq_q, irq_d;

    // Clear is applied first so that a toggle in the ack cycle survives.
    always_comb begin
        chg_d = irq_ack_i ? '0 : chg_q;
        chg_d = chg_d | sw_toggle;
        irq_d = |chg_q;
    end

    // ------------------------------------------------------------------
    // LED PWM
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]  bright_q,  bright_d;
    logic [LED_WIDTH-1:0] led_reg_q, led_reg_d;
    logic [LED_WIDTH-1:0] led_o_q,   led_o_d;
    logic                 duty_on;

    // Brightness is only reloaded on the last count of a period so every
    // period is generated with a single, consistent duty value. All-ones is
    // forced fully on because pwm_cnt < '1 would miss the final count.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        bright_d  = (pwm_cnt_q == '1) ? bright_i : bright_q;
        led_reg_d = led_bo_i;
        duty_on   = (bright_q == '1) || (pwm_cnt_q < bright_q);
        led_o_d   = led_reg_q & {LED_WIDTH{duty_on}};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            chg_q     <= '0;
            irq_q     <= 1'b0;
            pwm_cnt_q <= '0;
            bright_q  <= '0;
            led_reg_q <= '0;
            led_o_q   <= '0;
        end else begin
            chg_q     <= chg_d;
            irq_q     <= irq_d;
            pwm_cnt_q <= pwm_cnt_d;
            bright_q  <= bright_d;
            led_reg_q <= led_reg_d;
            led_o_q   <= led_o_d;
        end
    end

    assign sw_chg_o = chg_q;
    assign irq_o    = irq_q;
    assign led_o    = led_o_q;

endmodule

// File: tb/tb_board_gpio_ctrl.sv
// ----------------------------------------------------------------------------
// tb_board_gpio_ctrl
//   Self-checking bench for board_gpio_ctrl with DEB_CYCLES=4, PWM_BITS=4.
//   A behavioural model states the rules directly: a switch level is accepted
//   once its synchronized value has disagreed with the accepted level for the
//   last DEB_CYCLES samples; LEDs are on for the first `level` counts of each
//   16-count period, where level is latched at the end of the prior period.
// ----------------------------------------------------------------------------
module tb_board_gpio_ctrl;

    localparam int unsigned SW_W   = 16;
    localparam int unsigned LED_W  = 16;
    localparam int unsigned GPIO_W = 32;
    localparam int unsigned SW_OFF = 8;
    localparam int unsigned DEB    = 4;
    localparam int unsigned PB     = 4;
    localparam int unsigned PERIOD = 1 << PB;

    logic              clk = 1'b0;
    logic              srst;
    logic [SW_W-1:0]   sw;
    logic [GPIO_W-1:0] gpio;
    logic [LED_W-1:0]  led_bo;
    logic [PB-1:0]     bright;
    logic [LED_W-1:0]  led;
    logic [SW_W-1:0]   chg;
    logic              irq;
    logic              ack;

    always #5 clk = ~clk;

    board_gpio_ctrl #(
        .SW_WIDTH   (SW_W),
        .LED_WIDTH  (LED_W),
        .GPIO_WIDTH (GPIO_W),
        .SW_OFFSET  (SW_OFF),
        .DEB_CYCLES (DEB),
        .PWM_BITS   (PB)
    ) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .sw_i      (sw),
        .gpio_bi_o (gpio),
        .led_bo_i  (led_bo),
        .bright_i  (bright),
        .led_o     (led),
        .sw_chg_o  (chg),
        .irq_o     (irq),
        .irq_ack_i (ack)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- model
    logic [SW_W-1:0]  m_s1, m_s2, m_stable, m_chg, m_tog;
    logic [DEB-1:0]   m_hist [SW_W];
    logic             m_irq;
    int unsigned      m_phase;
    logic [PB-1:0]    m_level;
    logic [LED_W-1:0] m_pattern, m_led;
    bit               m_valid = 1'b0;

    always @(posedge clk) begin
        if (srst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_chg = '0; m_irq = 1'b0;
            for (int i = 0; i < SW_W; i++) m_hist[i] = '0;
            m_phase = 0; m_level = '0; m_pattern = '0; m_led = '0;
            m_valid = 1'b1;
        end else begin
            m_irq = |m_chg;
            m_tog = '0;
            for (int i = 0; i < SW_W; i++) begin
                m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
                if (m_hist[i] == {DEB{~m_stable[i]}}) begin
                    m_stable[i] = ~m_stable[i];
                    m_tog[i]    = 1'b1;
                end
            end
            if (ack) m_chg = '0;
            m_chg = m_chg | m_tog;
            m_s2 = m_s1;
            m_s1 = sw;
            m_led = (m_level == PB'(PERIOD - 1) || m_phase < int'(m_level)) ? m_pattern : '0;
            m_pattern = led_bo;
            if (m_phase == PERIOD - 1) m_level = bright;
            m_phase = (m_phase + 1) % PERIOD;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_gpio", 32'(gpio), 32'(m_stable) << SW_OFF);
            check("model_chg",  32'(chg),  32'(m_chg));
            check("model_irq",  32'(irq),  32'(m_irq));
            check("model_led",  32'(led),  32'(m_led));
        end
    end

    // ------------------------------------------------------------- stimulus
    int unsigned on_cnt;
    bit          seen;
    logic [LED_W-1:0] prev_led;

    initial begin
        srst = 1'b1; sw = '0; led_bo = '0; bright = '0; ack = 1'b0;
        tick(3);
        check("rst_gpio", 32'(gpio), 32'h0);
        check("rst_chg",  32'(chg),  32'h0);
        check("rst_irq",  32'(irq),  32'h0);
        check("rst_led",  32'(led),  32'h0);
        srst = 1'b0;
        tick(2);

        // single switch qualifies DEB+2 clocks after the pad changes
        sw = 16'h0001;
        tick(5);
        check("lat_gpio_pre", 32'(gpio), 32'h0);
        check("lat_chg_pre",  32'(chg),  32'h0);
        tick(1);
        check("lat_gpio", 32'(gpio), 32'h0000_0100);
        check("lat_chg",  32'(chg),  32'h0001);
        check("lat_irq0", 32'(irq),  32'h0);
        tick(1);
        check("lat_irq1", 32'(irq),  32'h1);

        // ack in the same cycle switch 5 qualifies: set wins
        sw = 16'h0021;
        tick(5);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ack_race_chg", 32'(chg), 32'h0020);
        check("ack_race_irq", 32'(irq), 32'h1);
        tick(1);
        check("ack_race_irq2", 32'(irq), 32'h1);

        // 3-clock glitch on switch 3 is rejected
        sw = 16'h0029;
        tick(3);
        sw = 16'h0021;
        tick(20);
        check("glitch_gpio", 32'(gpio), 32'h0000_2100);
        check("glitch_chg",  32'(chg),  32'h0020);

        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        check("ack_clr_chg", 32'(chg), 32'h0);
        check("ack_clr_irq", 32'(irq), 32'h1);
        tick(1);
        check("ack_irq_low", 32'(irq), 32'h0);

        // 4-clock pulse is exactly long enough; the release flips back
        sw = 16'h0029;
        tick(4);
        sw = 16'h0021;
        tick(2);
        check("pulse4_gpio", 32'(gpio), 32'h0000_2900);
        check("pulse4_chg",  32'(chg),  32'h0008);
        tick(3);
        check("pulse4_hold", 32'(gpio), 32'h0000_2900);
        tick(1);
        check("pulse4_fall",     32'(gpio), 32'h0000_2100);
        check("pulse4_fall_chg", 32'(chg),  32'h0008);

        // PWM at brightness 4
        led_bo = 16'hFFFF; bright = 4'h4;
        tick(40);
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (led == 16'hFFFF) on_cnt++;
        end
        check("pwm_b4_count", 32'(on_cnt), 32'd4);

        // find the start of an on-window, then change brightness mid-period
        seen = 1'b0;
        prev_led = led;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick(1);
            if (prev_led == '0 && led == 16'hFFFF) seen = 1'b1;
            prev_led = led;
        end
        check("pwm_rise_seen", 32'(seen), 32'h1);
        bright = 4'h8;
        on_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (led == 16'hFFFF) on_cnt++;
        end
        check("pwm_midchg_old", 32'(on_cnt), 32'd3);
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (led == 16'hFFFF) on_cnt++;
        end
        check("pwm_midchg_new", 32'(on_cnt), 32'd8);

        // full brightness and 2-clock pattern latency
        bright = 4'hF;
        tick(40);
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (led == 16'hFFFF) on_cnt++;
        end
        check("pwm_full_count", 32'(on_cnt), 32'd16);
        led_bo = 16'h00A5;
        tick(1);
        check("led_lat1", 32'(led), 32'h0000_FFFF);
        tick(1);
        check("led_lat2", 32'(led), 32'h0000_00A5);

        bright = 4'h0;
        tick(40);
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            if (led != '0) on_cnt++;
        end
        check("pwm_off_count", 32'(on_cnt), 32'd0);

        // reset mid-qualification discards the partial count
        sw = '0;
        tick(10);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(2);
        sw = 16'h0001;
        tick(4);
        srst = 1'b1;
        tick(1);
        srst = 1'b0;
        check("rst_mid_gpio", 32'(gpio), 32'h0);
        tick(5);
        check("rst_mid_chg_pre",  32'(chg),  32'h0);
        check("rst_mid_gpio_pre", 32'(gpio), 32'h0);
        tick(1);
        check("rst_mid_chg",  32'(chg),  32'h0001);
        check("rst_mid_gpio2", 32'(gpio), 32'h0000_0100);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
